// File: rtl/tcp_state_wr_ctrl.sv
// Purpose : write-port controller for the TCP state store (init sweep + 2-way round-robin writer arbitration).
// Latency : zero-cycle combinational pass-through from the granted writer to the store; 1 write/cycle.
// Backpr. : a grant is locked while the store stalls, so each beat is atomic; writer rdy follows store rdy.
//
// Ports
//   clk, rst                      clock and asynchronous active-low reset
//   fsm_ctrl_wr_req_*             receive-FSM write request (val/addr/state) and its rdy
//   setup_ctrl_wr_req_*           flow-setup write request (val/addr/state) and its rdy
//   clr_req_val / clr_req_rdy     full-table re-initialisation request
//   ctrl_tcp_state_wr_req_*       store write port (val/addr/state) with tcp_state_ctrl_wr_req_rdy
//   init_done                     table initialised; writers may be served
module tcp_state_wr_ctrl #(
    parameter int                 FLOWID_W     = 8,
    parameter int                 TCP_STATE_W  = 16,
    parameter int                 MAX_FLOW_CNT = 256,
    parameter int                 width_p      = TCP_STATE_W,
    parameter int                 els_p        = MAX_FLOW_CNT,
    parameter logic [width_p-1:0] init_state_p = '0
) (
    input  logic                clk,
    input  logic                rst,

    input  logic                fsm_ctrl_wr_req_val,
    input  logic [FLOWID_W-1:0] fsm_ctrl_wr_req_addr,
    input  logic [width_p-1:0]  fsm_ctrl_wr_req_state,
    output logic                ctrl_fsm_wr_req_rdy,

    input  logic                setup_ctrl_wr_req_val,
    input  logic [FLOWID_W-1:0] setup_ctrl_wr_req_addr,
    input  logic [width_p-1:0]  setup_ctrl_wr_req_state,
    output logic                ctrl_setup_wr_req_rdy,

    input  logic                clr_req_val,
    output logic                clr_req_rdy,

    output logic                ctrl_tcp_state_wr_req_val,
    output logic [FLOWID_W-1:0] ctrl_tcp_state_wr_req_addr,
    output logic [width_p-1:0]  ctrl_tcp_state_wr_req_state,
    input  logic                tcp_state_ctrl_wr_req_rdy,

    output logic                init_done
);

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_SWEEP = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    typedef enum logic {
        SRC_FSM   = 1'b0,
        SRC_SETUP = 1'b1
    } src_e;

    localparam logic [FLOWID_W-1:0] SWEEP_LAST = FLOWID_W'(els_p - 1);

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    state_e              state_q,     state_d;
    logic [FLOWID_W-1:0] sweep_cnt_q, sweep_cnt_d;
    src_e                rr_ptr_q,    rr_ptr_d;
    logic                lock_q,      lock_d;
    src_e                lock_src_q,  lock_src_d;
    logic                init_done_q, init_done_d;

    // ------------------------------------------------------------------
    // Arbitration
    // ------------------------------------------------------------------
    src_e                grant;
    logic                grant_vld;
    logic                sel_val;
    logic [FLOWID_W-1:0] sel_addr;
    logic [width_p-1:0]  sel_state;
    logic                run_vld;

    always_comb begin
        grant     = SRC_FSM;
        grant_vld = 1'b0;
        if (lock_q) begin
            // A stalled beat keeps its source until the store accepts it.
            grant     = lock_src_q;
            grant_vld = 1'b1;
        end else if (fsm_ctrl_wr_req_val && setup_ctrl_wr_req_val) begin
            grant     = rr_ptr_q;
            grant_vld = 1'b1;
        end else if (fsm_ctrl_wr_req_val) begin
            grant     = SRC_FSM;
            grant_vld = 1'b1;
        end else if (setup_ctrl_wr_req_val) begin
            grant     = SRC_SETUP;
            grant_vld = 1'b1;
        end
    end

    always_comb begin
        if (grant == SRC_FSM) begin
            sel_val   = fsm_ctrl_wr_req_val;
            sel_addr  = fsm_ctrl_wr_req_addr;
            sel_state = fsm_ctrl_wr_req_state;
        end else begin
            sel_val   = setup_ctrl_wr_req_val;
            sel_addr  = setup_ctrl_wr_req_addr;
            sel_state = setup_ctrl_wr_req_state;
        end
    end

    assign run_vld = grant_vld && sel_val;

    // ------------------------------------------------------------------
    // Port drive
    // ------------------------------------------------------------------
    logic                dn_val;
    logic [FLOWID_W-1:0] dn_addr;
    logic [width_p-1:0]  dn_state;
    logic                fsm_rdy;
    logic                setup_rdy;
    logic                clr_rdy;
    logic                dn_xfer;
    logic                clr_xfer;

    always_comb begin
        dn_val    = 1'b0;
        dn_addr   = '0;
        dn_state  = '0;
        fsm_rdy   = 1'b0;
        setup_rdy = 1'b0;
        clr_rdy   = 1'b0;
        case (state_q)
            ST_SWEEP: begin
                dn_val   = 1'b1;
                dn_addr  = sweep_cnt_q;
                dn_state = init_state_p;
            end
            ST_RUN: begin
                dn_val    = run_vld;
                if (run_vld) begin
                    dn_addr  = sel_addr;
                    dn_state = sel_state;
                end
                fsm_rdy   = run_vld && (grant == SRC_FSM)   && tcp_state_ctrl_wr_req_rdy;
                setup_rdy = run_vld && (grant == SRC_SETUP) && tcp_state_ctrl_wr_req_rdy;
                // Writes win: a clear is only taken on a cycle with no writer pending,
                // which also rules out a write and a clear transferring together.
                clr_rdy   = !lock_q && !fsm_ctrl_wr_req_val && !setup_ctrl_wr_req_val;
            end
            default: ;
        endcase
    end

    assign dn_xfer  = dn_val && tcp_state_ctrl_wr_req_rdy;
    assign clr_xfer = clr_req_val && clr_rdy;

    // ------------------------------------------------------------------
    // Next-state
    // ------------------------------------------------------------------
    always_comb begin
        state_d     = state_q;
        sweep_cnt_d = sweep_cnt_q;
        rr_ptr_d    = rr_ptr_q;
        lock_d      = lock_q;
        lock_src_d  = lock_src_q;
        init_done_d = init_done_q;
        case (state_q)
            ST_START: begin
                state_d     = ST_SWEEP;
                sweep_cnt_d = '0;
            end
            ST_SWEEP: begin
                if (dn_xfer) begin
                    if (sweep_cnt_q == SWEEP_LAST) begin
                        sweep_cnt_d = '0;
                        state_d     = ST_RUN;
                        init_done_d = 1'b1;
                    end else begin
                        sweep_cnt_d = sweep_cnt_q + FLOWID_W'(1);
                    end
                end
            end
            ST_RUN: begin
                if (dn_xfer) begin
                    rr_ptr_d = (grant == SRC_FSM) ? SRC_SETUP : SRC_FSM;
                    lock_d   = 1'b0;
                end else if (dn_val) begin
                    lock_d     = 1'b1;
                    lock_src_d = grant;
                end
                if (clr_xfer) begin
                    state_d     = ST_SWEEP;
                    init_done_d = 1'b0;
                    sweep_cnt_d = '0;
                end
            end
            default: begin
                state_d = ST_START;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= ST_START;
            sweep_cnt_q <= '0;
            rr_ptr_q    <= SRC_FSM;
            lock_q      <= 1'b0;
            lock_src_q  <= SRC_FSM;
            init_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sweep_cnt_q <= sweep_cnt_d;
            rr_ptr_q    <= rr_ptr_d;
            lock_q      <= lock_d;
            lock_src_q  <= lock_src_d;
            init_done_q <= init_done_d;
        end
    end

    assign ctrl_tcp_state_wr_req_val   = dn_val;
    assign ctrl_tcp_state_wr_req_addr  = dn_addr;
    assign ctrl_tcp_state_wr_req_state = dn_state;
    assign ctrl_fsm_wr_req_rdy         = fsm_rdy;
    assign ctrl_setup_wr_req_rdy       = setup_rdy;
    assign clr_req_rdy                 = clr_rdy;
    assign init_done                   = init_done_q;

    // A writer that drops val while its beat is stalled breaks atomicity.
    a_locked_val_held: assert property (
        @(posedge clk) disable iff (!rst)
        lock_q |-> sel_val
    );

endmodule

// File: tb/tb_tcp_state_wr_ctrl.sv
module tb_tcp_state_wr_ctrl;

    localparam int         FW   = 4;
    localparam int         SW   = 8;
    localparam int         ELS  = 4;
    localparam logic [7:0] INIT = 8'h3C;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          fv = 1'b0, sv = 1'b0, clr = 1'b0, dn_rdy = 1'b0;
    logic [FW-1:0] fa = '0, sa = '0;
    logic [SW-1:0] fs, ss;
    logic          frdy, srdy, crdy, dn_val, idone;
    logic [FW-1:0] dn_addr;
    logic [SW-1:0] dn_state;

    assign fs = {4'hA, fa};
    assign ss = {4'h5, sa};

    always #5 clk = ~clk;

    tcp_state_wr_ctrl #(
        .FLOWID_W     (FW),
        .TCP_STATE_W  (SW),
        .MAX_FLOW_CNT (ELS),
        .width_p      (SW),
        .els_p        (ELS),
        .init_state_p (INIT)
    ) dut (
        .clk                         (clk),
        .rst                         (rst),
        .fsm_ctrl_wr_req_val         (fv),
        .fsm_ctrl_wr_req_addr        (fa),
        .fsm_ctrl_wr_req_state       (fs),
        .ctrl_fsm_wr_req_rdy         (frdy),
        .setup_ctrl_wr_req_val       (sv),
        .setup_ctrl_wr_req_addr      (sa),
        .setup_ctrl_wr_req_state     (ss),
        .ctrl_setup_wr_req_rdy       (srdy),
        .clr_req_val                 (clr),
        .clr_req_rdy                 (crdy),
        .ctrl_tcp_state_wr_req_val   (dn_val),
        .ctrl_tcp_state_wr_req_addr  (dn_addr),
        .ctrl_tcp_state_wr_req_state (dn_state),
        .tcp_state_ctrl_wr_req_rdy   (dn_rdy),
        .init_done                   (idone)
    );

    int n_cmp  = 0;
    int n_fail = 0;

    // Observed vector layout: {val, addr, state, fsm_rdy, setup_rdy, clr_rdy, init_done}
    function automatic logic [16:0] ex(logic v, logic [3:0] a, logic [7:0] s,
                                       logic fr, logic sr, logic cr, logic id);
        return {v, a, s, fr, sr, cr, id};
    endfunction

    task automatic check(input string name, input logic [16:0] exp);
        logic [16:0] got;
        got = {dn_val, dn_addr, dn_state, frdy, srdy, crdy, idone};
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got v=%b a=%h s=%h fr=%b sr=%b cr=%b id=%b, want v=%b a=%h s=%h fr=%b sr=%b cr=%b id=%b",
                     name, got[16], got[15:12], got[11:4], got[3], got[2], got[1], got[0],
                     exp[16], exp[15:12], exp[11:4], exp[3], exp[2], exp[1], exp[0]);
        end
    endtask

    // Inputs change just after the rising edge; outputs are checked on the falling edge.
    task automatic drive(input logic f_v, input logic [3:0] f_a, input logic s_v,
                         input logic [3:0] s_a, input logic r, input logic c);
        fv = f_v; fa = f_a; sv = s_v; sa = s_a; dn_rdy = r; clr = c;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic       fv;
        logic [3:0] fa;
        logic       sv;
        logic [3:0] sa;
        logic       rdy;
        logic       ev;
        logic [3:0] ea;
        logic [7:0] es;
        logic       efr;
        logic       esr;
        logic       ecr;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(logic f_v, logic [3:0] f_a, logic s_v, logic [3:0] s_a, logic r,
                                logic e_v, logic [3:0] e_a, logic [7:0] e_s,
                                logic e_fr, logic e_sr, logic e_cr);
        vec_t t;
        t.fv = f_v; t.fa = f_a; t.sv = s_v; t.sa = s_a; t.rdy = r;
        t.ev = e_v; t.ea = e_a; t.es = e_s; t.efr = e_fr; t.esr = e_sr; t.ecr = e_cr;
        return t;
    endfunction

    initial begin
        // RUN-mode arbitration, applied one row per cycle from rr_ptr=FSM, unlocked.
        vecs[0]  = mk(0, 4'h0, 0, 4'h0, 1,  0, 4'h0, 8'h00, 0, 0, 1); // idle: clear may be taken
        vecs[1]  = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h5, 8'hA5, 1, 0, 0); // both: FSM first
        vecs[2]  = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h9, 8'h59, 0, 1, 0); // alternate to setup
        vecs[3]  = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h5, 8'hA5, 1, 0, 0);
        vecs[4]  = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h9, 8'h59, 0, 1, 0);
        vecs[5]  = mk(0, 4'h0, 1, 4'h9, 1,  1, 4'h9, 8'h59, 0, 1, 0); // sole setup, ptr was FSM
        vecs[6]  = mk(1, 4'h5, 0, 4'h0, 1,  1, 4'h5, 8'hA5, 1, 0, 0); // sole FSM
        vecs[7]  = mk(1, 4'h5, 0, 4'h0, 1,  1, 4'h5, 8'hA5, 1, 0, 0); // sole FSM, ptr at setup
        vecs[8]  = mk(1, 4'h5, 1, 4'h9, 0,  1, 4'h9, 8'h59, 0, 0, 0); // setup granted, stalled
        vecs[9]  = mk(1, 4'h5, 1, 4'h9, 0,  1, 4'h9, 8'h59, 0, 0, 0); // held
        vecs[10] = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h9, 8'h59, 0, 1, 0); // setup transfers
        vecs[11] = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h5, 8'hA5, 1, 0, 0); // FSM next
        vecs[12] = mk(0, 4'h0, 0, 4'h0, 1,  0, 4'h0, 8'h00, 0, 0, 1);
        vecs[13] = mk(1, 4'h5, 0, 4'h0, 0,  1, 4'h5, 8'hA5, 0, 0, 0); // FSM stalled, locks
        vecs[14] = mk(1, 4'h5, 1, 4'h9, 0,  1, 4'h5, 8'hA5, 0, 0, 0); // lock beats ptr=setup
        vecs[15] = mk(1, 4'h5, 1, 4'h9, 0,  1, 4'h5, 8'hA5, 0, 0, 0);
        vecs[16] = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h5, 8'hA5, 1, 0, 0); // FSM transfers
        vecs[17] = mk(1, 4'h5, 1, 4'h9, 1,  1, 4'h9, 8'h59, 0, 1, 0); // then setup
        vecs[18] = mk(0, 4'h0, 0, 4'h0, 0,  0, 4'h0, 8'h00, 0, 0, 1);

        // ---------------- reset and first sweep (store always ready) ----------------
        #1 rst = 1'b0;
        drive(0, 4'h0, 0, 4'h0, 1, 0);
        repeat (2) @(negedge clk);
        check("reset_idle", ex(0, 4'h0, 8'h00, 0, 0, 0, 0));
        rst = 1'b1;
        #1;
        check("start_idle", ex(0, 4'h0, 8'h00, 0, 0, 0, 0));
        for (int k = 0; k < ELS; k++) begin
            next_cycle();
            // Writers request during the sweep but must not be served.
            drive(k < ELS - 1, 4'h5, k < ELS - 1, 4'h9, 1, 0);
            @(negedge clk);
            check($sformatf("sweep_addr%0d", k), ex(1, 4'(k), INIT, 0, 0, 0, 0));
        end
        next_cycle();
        @(negedge clk);
        check("init_done_after_sweep", ex(0, 4'h0, 8'h00, 0, 0, 1, 1));

        // ---------------- table-driven RUN arbitration ----------------
        for (int i = 0; i < 19; i++) begin
            next_cycle();
            drive(vecs[i].fv, vecs[i].fa, vecs[i].sv, vecs[i].sa, vecs[i].rdy, 0);
            @(negedge clk);
            check($sformatf("run_vec%0d", i),
                  ex(vecs[i].ev, vecs[i].ea, vecs[i].es, vecs[i].efr, vecs[i].esr, vecs[i].ecr, 1));
        end

        // ---------------- clear, then sweep under toggling backpressure ----------------
        next_cycle();
        drive(0, 4'h0, 0, 4'h0, 1, 1);
        @(negedge clk);
        check("clr_rdy_idle", ex(0, 4'h0, 8'h00, 0, 0, 1, 1));
        for (int c = 0; c < 2 * ELS; c++) begin
            next_cycle();
            drive(c < 2 * ELS - 1, 4'h5, 0, 4'h0, c[0], 0);
            @(negedge clk);
            check($sformatf("bp_sweep_c%0d", c), ex(1, 4'(c / 2), INIT, 0, 0, 0, 0));
        end
        next_cycle();
        drive(0, 4'h0, 0, 4'h0, 1, 0);
        @(negedge clk);
        check("init_done_after_clear", ex(0, 4'h0, 8'h00, 0, 0, 1, 1));

        // ---------------- async reset mid-sweep at sweep_cnt=2 ----------------
        next_cycle();
        drive(0, 4'h0, 0, 4'h0, 1, 1);
        for (int k = 0; k < 3; k++) begin
            next_cycle();
            drive(0, 4'h0, 0, 4'h0, 1, 0);
            @(negedge clk);
            check($sformatf("pre_rst_addr%0d", k), ex(1, 4'(k), INIT, 0, 0, 0, 0));
        end
        rst = 1'b0;
        #1;
        check("async_rst_outputs", ex(0, 4'h0, 8'h00, 0, 0, 0, 0));
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("restart_start", ex(0, 4'h0, 8'h00, 0, 0, 0, 0));
        for (int k = 0; k < 2; k++) begin
            next_cycle();
            @(negedge clk);
            check($sformatf("restart_addr%0d", k), ex(1, 4'(k), INIT, 0, 0, 0, 0));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
